// File: rtl/serpent_lt_pipe.sv
// serpent_lt_pipe: elastic 1- or 2-stage Serpent linear transform; each beat selects forward or inverse.
// Optional macro SERPENT_LT_BYPASS_EN adds i_bypass, which passes a beat's words through untouched.
module serpent_lt_pipe #(
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_inv,
`ifdef SERPENT_LT_BYPASS_EN
  input  logic             i_bypass,
`endif
  input  logic [TAG_W-1:0] i_tag,
  input  logic [31:0]      i_word_0,
  input  logic [31:0]      i_word_1,
  input  logic [31:0]      i_word_2,
  input  logic [31:0]      i_word_3,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_word_0,
  output logic [31:0]      o_word_1,
  output logic [31:0]      o_word_2,
  output logic [31:0]      o_word_3,
  output logic             o_busy
);

  typedef logic [3:0][31:0] words_t;

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] v, input int n);
    return rol(v, 32 - n);
  endfunction

  // Both directions split after their first XOR pair, which is the stage A boundary.
  function automatic words_t frontHalf(input words_t x, input logic inv, input logic bypass);
    words_t y;
    y = x;
    if (!bypass) begin
      if (!inv) begin
        y[0] = rol(x[0], 13);
        y[2] = rol(x[2], 3);
        y[1] = x[1] ^ y[0] ^ y[2];
        y[3] = x[3] ^ y[2] ^ (y[0] << 3);
      end else begin
        y[0] = ror(x[0], 5) ^ x[1] ^ x[3];
        y[2] = ror(x[2], 22) ^ x[3] ^ (x[1] << 7);
      end
    end
    return y;
  endfunction

  function automatic words_t backHalf(input words_t x, input logic inv, input logic bypass);
    words_t y;
    y = x;
    if (!bypass) begin
      if (!inv) begin
        y[1] = rol(x[1], 1);
        y[3] = rol(x[3], 7);
        y[0] = rol(x[0] ^ y[1] ^ y[3], 5);
        y[2] = rol(x[2] ^ y[3] ^ (y[1] << 7), 22);
      end else begin
        y[3] = ror(x[3], 7) ^ x[2] ^ (x[0] << 3);
        y[1] = ror(x[1], 1) ^ x[0] ^ x[2];
        y[2] = ror(x[2], 3);
        y[0] = ror(x[0], 13);
      end
    end
    return y;
  endfunction

  logic bypassIn;
`ifdef SERPENT_LT_BYPASS_EN
  assign bypassIn = i_bypass;
`else
  assign bypassIn = 1'b0;
`endif

  words_t inWords;
  assign inWords = {i_word_3, i_word_2, i_word_1, i_word_0};

  logic             feedValid;
  logic             feedInv;
  logic             feedBypass;
  logic [TAG_W-1:0] feedTag;
  words_t           feedWords;
  logic             frontBusy;

  logic             outValid_q;
  logic [TAG_W-1:0] outTag_q;
  words_t           outWords_q;
  words_t           outWords_d;
  logic             outReady;

  assign outReady   = !outValid_q || i_ready;
  assign outWords_d = backHalf(feedWords, feedInv, feedBypass);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      outValid_q <= 1'b0;
      outTag_q   <= '0;
      outWords_q <= '0;
    end else if (outReady) begin
      outValid_q <= feedValid;
      if (feedValid) begin
        outTag_q   <= feedTag;
        outWords_q <= outWords_d;
      end
    end
  end

  generate
    if (STAGES == 1) begin : gSingle
      assign feedValid  = i_valid;
      assign feedInv    = i_inv;
      assign feedBypass = bypassIn;
      assign feedTag    = i_tag;
      assign feedWords  = frontHalf(inWords, i_inv, bypassIn);
      assign frontBusy  = 1'b0;
      assign o_ready    = outReady;
    end else if (STAGES == 2) begin : gDouble
      logic             aValid_q;
      logic             aInv_q;
      logic             aBypass_q;
      logic [TAG_W-1:0] aTag_q;
      words_t           aWords_q;
      words_t           aWords_d;
      logic             aReady;

      assign aReady   = !aValid_q || outReady;
      assign aWords_d = frontHalf(inWords, i_inv, bypassIn);

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          aValid_q  <= 1'b0;
          aInv_q    <= 1'b0;
          aBypass_q <= 1'b0;
          aTag_q    <= '0;
          aWords_q  <= '0;
        end else if (aReady) begin
          aValid_q <= i_valid;
          if (i_valid) begin
            aInv_q    <= i_inv;
            aBypass_q <= bypassIn;
            aTag_q    <= i_tag;
            aWords_q  <= aWords_d;
          end
        end
      end

      assign feedValid  = aValid_q;
      assign feedInv    = aInv_q;
      assign feedBypass = aBypass_q;
      assign feedTag    = aTag_q;
      assign feedWords  = aWords_q;
      assign frontBusy  = aValid_q;
      assign o_ready    = aReady;
    end else begin : gBadStages
      $error("serpent_lt_pipe: STAGES must be 1 or 2");
    end
  endgenerate

  assign o_valid  = outValid_q;
  assign o_tag    = outTag_q;
  assign o_word_0 = outWords_q[0];
  assign o_word_1 = outWords_q[1];
  assign o_word_2 = outWords_q[2];
  assign o_word_3 = outWords_q[3];
  assign o_busy   = outValid_q | frontBusy;

endmodule

// File: tb/tb_serpent_lt_pipe.sv
// Scoreboard bench for serpent_lt_pipe: drives a STAGES=1 and a STAGES=2 instance in turn.
// Build with SERPENT_LT_BYPASS_EN defined to also exercise the bypass port.
`timescale 1ns/1ps
module tb_serpent_lt_pipe;

  typedef logic [3:0][31:0] words_t;
  typedef struct packed {
    logic [3:0]  tag;
    words_t      words;
    logic [31:0] accCyc;
  } beat_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       drvValid = 1'b0;
  logic       drvInv = 1'b0;
  logic       drvBypass = 1'b0;
  logic       drvReady = 1'b1;
  logic [3:0] drvTag = '0;
  words_t     drvWords = '0;
  int         sel = 0;
  bit         latCheck = 1'b0;
  logic [31:0] cyc = '0;

  logic        inValid [2];
  logic        oReady  [2];
  logic        oValid  [2];
  logic        oBusy   [2];
  logic [3:0]  oTag    [2];
  logic [31:0] oW0 [2];
  logic [31:0] oW1 [2];
  logic [31:0] oW2 [2];
  logic [31:0] oW3 [2];

  beat_t q0[$];
  beat_t q1[$];

  int checkCount = 0;
  int passCount  = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 32'd1;

  for (genvar g = 0; g < 2; g++) begin : gDut
    assign inValid[g] = drvValid && (sel == g);
    serpent_lt_pipe #(.STAGES(g + 1), .TAG_W(4)) dut (
      .i_clk(clock),
      .i_rst(reset),
      .i_valid(inValid[g]),
      .o_ready(oReady[g]),
      .i_inv(drvInv),
`ifdef SERPENT_LT_BYPASS_EN
      .i_bypass(drvBypass),
`endif
      .i_tag(drvTag),
      .i_word_0(drvWords[0]),
      .i_word_1(drvWords[1]),
      .i_word_2(drvWords[2]),
      .i_word_3(drvWords[3]),
      .o_valid(oValid[g]),
      .i_ready(drvReady),
      .o_tag(oTag[g]),
      .o_word_0(oW0[g]),
      .o_word_1(oW1[g]),
      .o_word_2(oW2[g]),
      .o_word_3(oW3[g]),
      .o_busy(oBusy[g])
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Reference model written straight from the step list, rotations via a doubled word.
  function automatic logic [31:0] mRol(input logic [31:0] v, input int n);
    logic [63:0] t;
    t = {v, v} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] mRor(input logic [31:0] v, input int n);
    logic [63:0] t;
    t = {v, v} >> n;
    return t[31:0];
  endfunction

  function automatic words_t modelFwd(input words_t w);
    logic [31:0] x0, x1, x2, x3;
    x0 = w[0]; x1 = w[1]; x2 = w[2]; x3 = w[3];
    x0 = mRol(x0, 13); x2 = mRol(x2, 3);
    x1 = x1 ^ x0 ^ x2; x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = mRol(x1, 1); x3 = mRol(x3, 7);
    x0 = x0 ^ x1 ^ x3; x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = mRol(x0, 5); x2 = mRol(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  function automatic words_t modelInv(input words_t w);
    logic [31:0] x0, x1, x2, x3;
    x0 = w[0]; x1 = w[1]; x2 = w[2]; x3 = w[3];
    x0 = mRor(x0, 5); x2 = mRor(x2, 22);
    x0 = x0 ^ x1 ^ x3; x2 = x2 ^ x3 ^ (x1 << 7);
    x1 = mRor(x1, 1); x3 = mRor(x3, 7);
    x3 = x3 ^ x2 ^ (x0 << 3); x1 = x1 ^ x0 ^ x2;
    x2 = mRor(x2, 3); x0 = mRor(x0, 13);
    return {x3, x2, x1, x0};
  endfunction

  function automatic int qSize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic pushExp(input int k, input beat_t b);
    if (k == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  // Every output transfer pops the oldest expected beat; latency is only checked when the sink never stalls.
  always @(negedge clock) begin
    beat_t e;
    for (int k = 0; k < 2; k++) begin
      if (!reset && oValid[k] && drvReady) begin
        if (qSize(k) == 0) begin
          checkOutput($sformatf("s%0d_sbEmpty", k + 1), 32'(qSize(k)), 32'd1);
        end else begin
          if (k == 0) e = q0.pop_front();
          else e = q1.pop_front();
          checkOutput($sformatf("s%0d_tag", k + 1), 32'(oTag[k]), 32'(e.tag));
          checkOutput($sformatf("s%0d_word0", k + 1), oW0[k], e.words[0]);
          checkOutput($sformatf("s%0d_word1", k + 1), oW1[k], e.words[1]);
          checkOutput($sformatf("s%0d_word2", k + 1), oW2[k], e.words[2]);
          checkOutput($sformatf("s%0d_word3", k + 1), oW3[k], e.words[3]);
          if (latCheck && k == sel)
            checkOutput($sformatf("s%0d_latency", k + 1), cyc - e.accCyc, 32'(k));
        end
      end
    end
  end

  task automatic applyStimulus(input logic inv, input logic byp, input logic [3:0] tag,
                               input words_t x, input words_t exp);
    bit    accepted;
    beat_t b;
    accepted  = 1'b0;
    drvValid  = 1'b1;
    drvInv    = inv;
    drvBypass = byp;
    drvTag    = tag;
    drvWords  = x;
    for (int w = 0; w < 100 && !accepted; w++) begin
      @(negedge clock);
      if (oReady[sel] && !reset) begin
        b.tag    = tag;
        b.words  = exp;
        b.accCyc = cyc + 32'd1;
        pushExp(sel, b);
        accepted = 1'b1;
      end
      @(posedge clock); #1;
    end
    drvValid  = 1'b0;
    drvBypass = 1'b0;
    if (!accepted) checkOutput("acceptTimeout", 32'(accepted), 32'd1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((qSize(sel) != 0 || oBusy[sel]) && w < 100) begin
      @(posedge clock); #1;
      w++;
    end
    checkOutput($sformatf("s%0d_drainQueue", sel + 1), 32'(qSize(sel)), 32'd0);
    checkOutput($sformatf("s%0d_drainBusy", sel + 1), 32'(oBusy[sel]), 32'd0);
  endtask

  task automatic checkIdle(input string pfx);
    @(negedge clock);
    checkOutput({pfx, "_valid"}, 32'(oValid[sel]), 32'd0);
    checkOutput({pfx, "_busy"}, 32'(oBusy[sel]), 32'd0);
    checkOutput({pfx, "_ready"}, 32'(oReady[sel]), 32'd1);
    checkOutput({pfx, "_tag"}, 32'(oTag[sel]), 32'd0);
    checkOutput({pfx, "_word0"}, oW0[sel], 32'd0);
    checkOutput({pfx, "_word1"}, oW1[sel], 32'd0);
    checkOutput({pfx, "_word2"}, oW2[sel], 32'd0);
    checkOutput({pfx, "_word3"}, oW3[sel], 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    words_t x, y, stallExp;
    logic [3:0] stallTag;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel = s;
      $display("[TB] testing STAGES=%0d", s + 1);
      checkIdle($sformatf("s%0d_resetState", s + 1));

      latCheck = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'h1, {32'h0, 32'h0, 32'h0, 32'h1},
                    {32'h0080_0000, 32'h0000_2800, 32'h0000_4000, 32'h100C_0000});
      applyStimulus(1'b1, 1'b0, 4'h2, {32'h0080_0000, 32'h0000_2800, 32'h0000_4000, 32'h100C_0000},
                    {32'h0, 32'h0, 32'h0, 32'h1});
      drain();

      for (int i = 0; i < 8; i++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(i[0], 1'b0, i[3:0], x, i[0] ? modelInv(x) : modelFwd(x));
      end
      drain();
      latCheck = 1'b0;

      for (int i = 0; i < 1000; i++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        y = modelFwd(x);
        applyStimulus(1'b0, 1'b0, i[3:0], x, y);
        applyStimulus(1'b1, 1'b0, ~i[3:0], y, x);
      end
      drain();

      // Fill the pipe with the sink stalled, offer one more beat, then release.
      drvReady = 1'b0;
      x = {$urandom, $urandom, $urandom, $urandom};
      stallExp = modelFwd(x);
      stallTag = 4'hA;
      applyStimulus(1'b0, 1'b0, stallTag, x, stallExp);
      if (s == 1) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(1'b1, 1'b0, 4'hB, x, modelInv(x));
      end
      drvValid = 1'b1;
      drvTag   = 4'hC;
      for (int c = 0; c < 5; c++) begin
        @(negedge clock);
        checkOutput($sformatf("s%0d_stallReady", s + 1), 32'(oReady[s]), 32'd0);
        checkOutput($sformatf("s%0d_stallValid", s + 1), 32'(oValid[s]), 32'd1);
        checkOutput($sformatf("s%0d_stallTag", s + 1), 32'(oTag[s]), 32'(stallTag));
        checkOutput($sformatf("s%0d_stallWord0", s + 1), oW0[s], stallExp[0]);
        checkOutput($sformatf("s%0d_stallWord3", s + 1), oW3[s], stallExp[3]);
        @(posedge clock); #1;
      end
      drvValid = 1'b0;
      drvReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(1'b0, 1'b0, 4'(i + 3), x, modelFwd(x));
      end
      drain();

      // Flush beats in flight; a beat offered during reset must also vanish.
      drvReady = 1'b0;
      for (int i = 0; i <= s; i++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(1'b0, 1'b0, 4'(13 + i), x, modelFwd(x));
      end
      reset    = 1'b1;
      drvValid = 1'b1;
      drvTag   = 4'hF;
      q0.delete();
      q1.delete();
      @(posedge clock); #1;
      reset    = 1'b0;
      drvValid = 1'b0;
      drvReady = 1'b1;
      checkIdle($sformatf("s%0d_afterFlush", s + 1));
      for (int i = 0; i < 3; i++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(1'b1, 1'b0, 4'(5 + i), x, modelInv(x));
      end
      drain();

`ifdef SERPENT_LT_BYPASS_EN
      x = {32'h3, 32'h2, 32'h1, 32'hDEAD_BEEF};
      applyStimulus(1'b0, 1'b1, 4'h9, x, x);
      applyStimulus(1'b1, 1'b1, 4'h8, x, x);
      y = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b0, 1'b0, 4'h7, y, modelFwd(y));
      drain();
`else
      $display("[TB] bypass port not present in this build");
`endif
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
